// File: rtl/esclusa_pkg.sv
// Shared types for the airlock controller: state encoding, door side and motor codes.
// Helper functions map a door side onto its OPEN/HOLD/CLOSE states.
package esclusa_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPEN_A  = 3'd1,
    S_HOLD_A  = 3'd2,
    S_CLOSE_A = 3'd3,
    S_OPEN_B  = 3'd4,
    S_HOLD_B  = 3'd5,
    S_CLOSE_B = 3'd6,
    S_ALARM   = 3'd7
  } state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  localparam logic [1:0] MOTOR_STOP  = 2'b00;
  localparam logic [1:0] MOTOR_OPEN  = 2'b01;
  localparam logic [1:0] MOTOR_CLOSE = 2'b10;

  function automatic state_t open_of(input side_t side);
    return (side == SIDE_A) ? S_OPEN_A : S_OPEN_B;
  endfunction

  function automatic state_t hold_of(input side_t side);
    return (side == SIDE_A) ? S_HOLD_A : S_HOLD_B;
  endfunction

  function automatic state_t close_of(input side_t side);
    return (side == SIDE_A) ? S_CLOSE_A : S_CLOSE_B;
  endfunction

  // Door served by a state; IDLE and ALARM fall back to the recorded door.
  function automatic side_t side_of(input state_t s, input side_t act);
    side_t r;
    case (s)
      S_OPEN_A, S_HOLD_A, S_CLOSE_A: r = SIDE_A;
      S_OPEN_B, S_HOLD_B, S_CLOSE_B: r = SIDE_B;
      default:                       r = act;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] motor_of(input state_t s, input side_t side);
    logic [1:0] m;
    m = MOTOR_STOP;
    if (s == open_of(side)) begin
      m = MOTOR_OPEN;
    end else if (s == close_of(side)) begin
      m = MOTOR_CLOSE;
    end
    return m;
  endfunction

endpackage

// File: rtl/esclusa_ctrl_tick_gen.sv
// Prescaler producing a one-clock tick every DIVISOR clocks.
// Reset also restarts the phase so a freshly entered state sees full tick periods.
module tick_gen #(
  parameter int DIVISOR = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/esclusa_ctrl.sv
// Two-door airlock controller: at most one door leaves the closed position at a time,
// requests are latched and served round-robin, an obstacle while opening raises ALARM.
module esclusa_ctrl
  import esclusa_pkg::*;
#(
  parameter int DIVISOR      = 50000000,
  parameter int TRAVEL_TICKS = 3,
  parameter int HOLD_TICKS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       obs_a,
  input  logic       obs_b,
  output logic [1:0] motor_a,
  output logic [1:0] motor_b,
  output logic       alarm,
  output logic       busy
);

  localparam int TMAX = (TRAVEL_TICKS > HOLD_TICKS) ? TRAVEL_TICKS : HOLD_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);

  state_t        state;
  state_t        nxt;
  side_t         act;
  side_t         last_served;
  side_t         cur;
  logic          pend_a;
  logic          pend_b;
  logic [TW-1:0] timer;
  logic          tick;
  logic          tclr;
  logic          tinc;
  logic          served;
  logic          restart;
  logic          req_c;
  logic          obs_c;
  logic          a_active;
  logic          b_active;

  // Any state change or hold re-arm restarts both timer and prescaler phase,
  // so every stroke and hold lasts exactly its tick count in clocks.
  tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick (
    .clk (clk),
    .rst (rst | restart),
    .tick(tick)
  );

  assign cur      = side_of(state, act);
  assign req_c    = (cur == SIDE_A) ? req_a : req_b;
  assign obs_c    = (cur == SIDE_A) ? obs_a : obs_b;
  assign a_active = (state != S_IDLE) && (cur == SIDE_A);
  assign b_active = (state != S_IDLE) && (cur == SIDE_B);
  assign restart  = tclr || (nxt != state);

  always_comb begin
    nxt    = state;
    tclr   = 1'b0;
    tinc   = 1'b0;
    served = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_a && pend_b) begin
          nxt = (last_served == SIDE_B) ? S_OPEN_A : S_OPEN_B;
        end else if (pend_a) begin
          nxt = S_OPEN_A;
        end else if (pend_b) begin
          nxt = S_OPEN_B;
        end
      end
      S_OPEN_A, S_OPEN_B: begin
        if (obs_c) begin
          nxt = S_ALARM;
        end else if (tick) begin
          if (timer == TRAVEL_LAST) nxt = hold_of(cur);
          else                      tinc = 1'b1;
        end
      end
      S_HOLD_A, S_HOLD_B: begin
        if (req_c || obs_c) begin
          tclr = 1'b1;
        end else if (tick) begin
          if (timer == HOLD_LAST) nxt = close_of(cur);
          else                    tinc = 1'b1;
        end
      end
      S_CLOSE_A, S_CLOSE_B: begin
        // Reopening from a partial close is treated as a full stroke.
        if (req_c || obs_c) begin
          nxt = open_of(cur);
        end else if (tick) begin
          if (timer == TRAVEL_LAST) begin
            nxt    = S_IDLE;
            served = 1'b1;
          end else begin
            tinc = 1'b1;
          end
        end
      end
      S_ALARM: begin
        if (!obs_c) nxt = open_of(cur);
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      act         <= SIDE_A;
      last_served <= SIDE_B;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      timer       <= '0;
    end else begin
      state <= nxt;
      if (restart)   timer <= '0;
      else if (tinc) timer <= timer + TW'(1);
      if (nxt == S_ALARM && state != S_ALARM) act <= cur;
      if (served) last_served <= cur;
      // Entry into OPEN_x consumes the request; the active door ignores its own side.
      if (nxt == S_OPEN_A && state != S_OPEN_A) pend_a <= 1'b0;
      else if (req_a && !a_active)              pend_a <= 1'b1;
      if (nxt == S_OPEN_B && state != S_OPEN_B) pend_b <= 1'b0;
      else if (req_b && !b_active)              pend_b <= 1'b1;
    end
  end

  assign motor_a = motor_of(state, SIDE_A);
  assign motor_b = motor_of(state, SIDE_B);
  assign alarm   = (state == S_ALARM);
  assign busy    = (state != S_IDLE);

endmodule

// File: doc/esclusa_ctrl.md
ESCLUSA_CTRL -- requirements
Module: esclusa_ctrl

Interface
REQ-001 SHALL have parameter DIVISOR, default 50000000, clk cycles per timing tick (1 Hz at 50 MHz).
REQ-002 SHALL have parameter TRAVEL_TICKS, default 3, ticks of motor run for a full open or close stroke.
REQ-003 SHALL have parameter HOLD_TICKS, default 5, ticks a door stays open with no request and no obstacle.
REQ-004 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_a  input  1  presence or request, side A; level, sampled every clk.
REQ-007 SHALL have port req_b  input  1  presence or request, side B.
REQ-008 SHALL have port obs_a  input  1  obstacle in door A.
REQ-009 SHALL have port obs_b  input  1  obstacle in door B.
REQ-010 SHALL have port motor_a  output  2  door A motor: 00 stop, 01 open, 10 close.
REQ-011 SHALL have port motor_b  output  2  door B motor, same encoding.
REQ-012 SHALL have port alarm  output  1  high while in ALARM.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL generate a 1-clk tick pulse every DIVISOR clk cycles; all timing counts ticks only.
REQ-015 SHALL implement states IDLE, OPEN_A, HOLD_A, CLOSE_A, OPEN_B, HOLD_B, CLOSE_B, ALARM; at most one door is out of the closed position at any time.
REQ-016 SHALL latch req_x into pend_x on any clk where req_x=1; pend_x clears on entry to OPEN_x; req_x does not set pend_x while door x is the active door.
REQ-017 IDLE: with one pend bit set, go to OPEN_x of that side; with both set, serve the side not served last (round-robin; last_served resets to B, so A wins the first tie).
REQ-018 OPEN_x: motor_x=01; timer cleared on entry; after TRAVEL_TICKS ticks go to HOLD_x.
REQ-019 OPEN_x with obs_x=1: go to ALARM on the next clk; active door is recorded.
REQ-020 HOLD_x: motors 00; timer clears on any clk with req_x=1 or obs_x=1; after HOLD_TICKS consecutive clear ticks go to CLOSE_x.
REQ-021 CLOSE_x: motor_x=10; after TRAVEL_TICKS ticks go to IDLE and set last_served=x.
REQ-022 CLOSE_x with req_x=1 or obs_x=1: go to OPEN_x on the next clk with the timer cleared (reopen is a full stroke).
REQ-023 ALARM: both motors 00, alarm=1; stay while obs of the active door is 1; on the first clk it is 0, go to OPEN_x of the active door.
REQ-024 Requests from the inactive side SHALL stay pending through the whole cycle, including ALARM, and are served from IDLE only.
REQ-025 Outputs SHALL be Moore: decoded from the state register only, with no combinational path from any input.
REQ-026 Timer width SHALL be $clog2(max(TRAVEL_TICKS,HOLD_TICKS)+1); prescaler width SHALL be $clog2(DIVISOR); neither counter saturates or wraps inside a state.
REQ-027 A tick and a state-changing event on the same clk: the event wins, and the timer is cleared for the new state.

Reset
REQ-028 With rst=1 at a clk edge: state IDLE, pend_a=pend_b=0, last_served=B, timer=0, prescaler=0, motor_a=motor_b=00, alarm=0, busy=0.
REQ-029 Reset mid-stroke SHALL stop both motors on the next clk; reset has priority over all inputs.

Structure
REQ-030 Package esclusa_pkg SHALL hold the state encoding and the motor codes MOTOR_STOP, MOTOR_OPEN, MOTOR_CLOSE.
REQ-031 The prescaler SHALL be sub-module tick_gen (parameter DIVISOR, ports clk, rst, tick).

Verification (DIVISOR=4, TRAVEL_TICKS=3, HOLD_TICKS=5)
REQ-032 Pulse req_a for 1 clk -> motor_a=01 for 12 clk, then 00 for 20 clk, then 10 for 12 clk, then IDLE with busy=0.
REQ-033 req_a and req_b both high on the same clk after reset -> door A is served fully, then door B, with motor_b=00 throughout the A cycle.
REQ-034 obs_b=1 at the 2nd tick of OPEN_B -> alarm=1 and motors 00 until obs_b falls; 1 clk later motor_b=01 for a full 12-clk stroke.
REQ-035 req_a=1 during CLOSE_A -> motor_a goes from 10 to 01 on the next clk, and the OPEN_A stroke restarts at 12 clk.
REQ-036 obs_a held high for 40 clk in HOLD_A -> the door stays in HOLD_A; CLOSE_A starts 20 clk after obs_a falls.
REQ-037 rst=1 for 1 clk in the middle of CLOSE_B with pend_a set -> next clk: all outputs 0, pend_a=0, and the block stays in IDLE.
